// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int REG_IDX_W      = 5;
    localparam int MD_LAT_DEFAULT = 32;
    localparam int MD_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_e;

    function automatic logic src_hit(
        input logic                 src_en,
        input logic [REG_IDX_W-1:0] src_idx,
        input logic [REG_IDX_W-1:0] dst_idx
    );
        return src_en && (src_idx == dst_idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// hazard_perf_cnt : saturating event counter with enable
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush generation, mul/div sequencing, mem wait handling
// Optional stall counter enabled by HAZARD_CTRL_PERF_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic                 id_rs1_en,
    input  logic                 id_rs2_en,
    input  logic [REG_IDX_W-1:0] exe_rd_idx,
    input  logic                 exe_rd_en,
    input  logic                 exe_is_load,
    input  logic                 exe_md_start,
    input  logic                 exe_br_taken,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 md_busy,
    output logic                 md_done,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_exe,
    output logic                 stall_mem,
    output logic                 flush_id,
    output logic                 flush_exe,
    output logic                 flush_mem,
    output logic                 flush_wb,
    output logic [1:0]           ctrl_state,
    output logic [PERF_W-1:0]    perf_stall_cnt
);

    ctrl_state_e           state;
    ctrl_state_e           ret_state;
    ctrl_state_e           eff_state;
    logic [MD_CNT_W-1:0]   md_cnt;
    logic                  mem_wait;
    logic                  md_wait;
    logic                  md_issue;
    logic                  load_use;

    // On the ack cycle MEM_WAIT already behaves like the state it returns to.
    always_comb begin
        eff_state = ST_RUN;
        case (state)
            ST_MD_WAIT:  eff_state = ST_MD_WAIT;
            ST_MEM_WAIT: eff_state = ret_state;
            default:     eff_state = ST_RUN;
        endcase
    end

    assign mem_wait = mem_req & ~mem_ack;
    assign md_wait  = (eff_state == ST_MD_WAIT);
    assign md_issue = (eff_state == ST_RUN) & exe_md_start;
    assign load_use = (eff_state == ST_RUN) & exe_is_load & exe_rd_en & (|exe_rd_idx) &
                      (src_hit(id_rs1_en, id_rs1_idx, exe_rd_idx) |
                       src_hit(id_rs2_en, id_rs2_idx, exe_rd_idx));

    always_comb begin
        logic s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, f_wb, busy, done;
        {s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, f_wb, busy, done} = '0;
        if (!rst) begin
            if (mem_wait) begin
                {s_if, s_id, s_exe, s_mem, f_wb} = 5'b11111;
                busy = md_wait;
            end else begin
                if (md_wait) begin
                    busy = 1'b1;
                    if (md_cnt == MD_CNT_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        {s_if, s_id, s_exe, f_mem} = 4'b1111;
                    end
                end else if (md_issue) begin
                    busy = 1'b1;
                    {s_if, s_id, s_exe, f_mem} = 4'b1111;
                end else if (load_use) begin
                    {s_if, s_id, f_exe} = 3'b111;
                end
                // A taken branch only acts once EXE is free to advance.
                if (exe_br_taken && !s_exe) begin
                    {f_id, f_exe} = 2'b11;
                    {s_if, s_id}  = 2'b00;
                end
            end
        end
        stall_if  = s_if;
        stall_id  = s_id  & ~f_id;
        stall_exe = s_exe & ~f_exe;
        stall_mem = s_mem & ~f_mem;
        flush_id  = f_id;
        flush_exe = f_exe;
        flush_mem = f_mem;
        flush_wb  = f_wb;
        md_busy   = busy;
        md_done   = done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            md_cnt    <= '0;
        end else if (mem_wait) begin
            if (state != ST_MEM_WAIT) begin
                ret_state <= (state == ST_MD_WAIT) ? ST_MD_WAIT : ST_RUN;
            end
            state <= ST_MEM_WAIT;
        end else if (md_wait) begin
            if (md_cnt == MD_CNT_W'(1)) begin
                state  <= ST_RUN;
                md_cnt <= '0;
            end else begin
                state  <= ST_MD_WAIT;
                md_cnt <= md_cnt - 1'b1;
            end
        end else if (exe_md_start) begin
            state  <= ST_MD_WAIT;
            md_cnt <= MD_CNT_W'(MD_LAT - 1);
        end else begin
            state <= ST_RUN;
        end
    end

    assign ctrl_state = state;

`ifdef HAZARD_CTRL_PERF_EN
    hazard_perf_cnt #(
        .WIDTH (PERF_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_if),
        .count (perf_stall_cnt)
    );
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed and randomized checks of hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int PERF_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1_idx, id_rs2_idx, exe_rd_idx;
    logic id_rs1_en, id_rs2_en, exe_rd_en, exe_is_load, exe_md_start, exe_br_taken;
    logic mem_req, mem_ack;
    logic md_busy, md_done, stall_if, stall_id, stall_exe, stall_mem;
    logic flush_id, flush_exe, flush_mem, flush_wb;
    logic [1:0] ctrl_state;
    logic [PERF_W-1:0] perf_stall_cnt;

    hazard_ctrl #(.MD_LAT(MD_LAT), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .exe_rd_idx(exe_rd_idx), .exe_rd_en(exe_rd_en), .exe_is_load(exe_is_load),
        .exe_md_start(exe_md_start), .exe_br_taken(exe_br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .md_busy(md_busy), .md_done(md_done),
        .stall_if(stall_if), .stall_id(stall_id), .stall_exe(stall_exe), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_exe(flush_exe), .flush_mem(flush_mem), .flush_wb(flush_wb),
        .ctrl_state(ctrl_state), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of mul/div work left, whether last cycle waited on memory.
    int m_md_left;
    bit m_in_mem;
    int m_perf;
    logic [9:0] e_ctl;
    logic [9:0] obs_ctl;
    logic [1:0] obs_state;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_md_left = 0;
        m_in_mem  = 1'b0;
        m_perf    = 0;
    endtask

    // Bit order: busy done s_if s_id s_exe s_mem f_id f_exe f_mem f_wb
    function automatic logic [9:0] model_ctl();
        logic busy, done, sif, sid, sexe, smem, fid, fexe, fmem, fwb, hold_exe, hz;
        {busy, done, sif, sid, sexe, smem, fid, fexe, fmem, fwb} = '0;
        hold_exe = 1'b0;
        if (rst) return '0;
        hz = exe_is_load && exe_rd_en && (exe_rd_idx != 0) &&
             ((id_rs1_en && id_rs1_idx == exe_rd_idx) || (id_rs2_en && id_rs2_idx == exe_rd_idx));
        if (mem_req && !mem_ack) begin
            {sif, sid, sexe, smem, fwb} = 5'b11111;
            busy = (m_md_left > 0);
        end else begin
            if (m_md_left == 1) begin
                busy = 1; done = 1;
            end else if (m_md_left > 1 || exe_md_start) begin
                busy = 1; sif = 1; sid = 1; sexe = 1; fmem = 1; hold_exe = 1;
            end else if (hz) begin
                sif = 1; sid = 1; fexe = 1;
            end
            if (exe_br_taken && !hold_exe) begin
                fid = 1; fexe = 1; sif = 0; sid = 0;
            end
        end
        return {busy, done, sif, sid, sexe, smem, fid, fexe, fmem, fwb};
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            if (e_ctl[7] && m_perf < (1 << PERF_W) - 1) m_perf++;
            if (mem_req && !mem_ack) begin
                m_in_mem = 1'b1;
            end else begin
                m_in_mem = 1'b0;
                if (m_md_left > 0) m_md_left--;
                else if (exe_md_start) m_md_left = MD_LAT - 1;
            end
        end
    endtask

    task automatic run_cycle();
        logic [1:0] e_state;
        logic [PERF_W-1:0] e_perf;
        @(negedge clk);
        if (rst) model_reset();
        e_ctl   = model_ctl();
        e_state = m_in_mem ? 2'd2 : ((m_md_left > 0) ? 2'd1 : 2'd0);
`ifdef HAZARD_CTRL_PERF_EN
        e_perf = PERF_W'(m_perf);
`else
        e_perf = '0;
`endif
        obs_ctl   = {md_busy, md_done, stall_if, stall_id, stall_exe, stall_mem,
                     flush_id, flush_exe, flush_mem, flush_wb};
        obs_state = ctrl_state;
        check_value("ctl", 64'(obs_ctl), 64'(e_ctl));
        check_value("state", 64'(obs_state), 64'(e_state));
        check_value("perf", 64'(perf_stall_cnt), 64'(e_perf));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_idx = 0; id_rs2_idx = 0; id_rs1_en = 0; id_rs2_en = 0;
        exe_rd_idx = 0; exe_rd_en = 0; exe_is_load = 0; exe_md_start = 0;
        exe_br_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        exe_is_load = 1; exe_rd_en = 1; exe_rd_idx = rd;
        id_rs1_en = 1; id_rs1_idx = rd;
    endtask

    initial begin
        int done_at;
        logic [1:0] seq [5];
        model_reset();
        idle_inputs();
        rst = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Load-use on x5, then the same pattern on x0.
        set_load_use(5'd5);
        run_cycle();
        check_value("lu_stall", 64'(obs_ctl[7:4] & 4'b1100), 64'(4'b1100));
        check_value("lu_flush_exe", 64'(obs_ctl[2]), 64'd1);
        idle_inputs();
        run_cycle();
        set_load_use(5'd0);
        run_cycle();
        check_value("x0_no_stall", 64'(obs_ctl), 64'd0);
        idle_inputs();

        // Plain mul/div.
        done_at = -1;
        exe_md_start = 1;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            exe_md_start = 0;
            if (obs_ctl[8] && done_at < 0) done_at = i;
            if (i == 4) check_value("md_ret_run", 64'(obs_state), 64'd0);
        end
        check_value("md_done_cycle", 64'(done_at), 64'(MD_LAT - 1));

        // Mem wait with ack at cycle 3, then same-cycle ack.
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            run_cycle();
            if (i == 2) check_value("mem_stall", 64'(obs_ctl[7:4]), 64'hf);
        end
        check_value("mem_ack_state", 64'(obs_state), 64'd2);
        mem_ack = 1;
        run_cycle();
        check_value("mem_ack0", 64'(obs_ctl), 64'd0);
        idle_inputs();
        run_cycle();

        // Mul/div interrupted by a three-cycle memory wait.
        done_at = -1;
        exe_md_start = 1;
        for (int i = 0; i < 9; i++) begin
            mem_req = (i >= 1 && i <= 4);
            mem_ack = (i == 4);
            run_cycle();
            exe_md_start = 0;
            if (i >= 1 && i <= 5) seq[i-1] = obs_state;
            if (obs_ctl[8] && done_at < 0) done_at = i;
        end
        check_value("mdmem_done_cycle", 64'(done_at), 64'(MD_LAT - 1 + 3));
        check_value("mdmem_seq", 64'({seq[0], seq[1], seq[2], seq[3], seq[4]}),
                    64'({2'd1, 2'd2, 2'd2, 2'd2, 2'd1}));
        idle_inputs();

        // Branch coinciding with load-use.
        set_load_use(5'd7);
        exe_br_taken = 1;
        run_cycle();
        check_value("br_lu", 64'(obs_ctl[7:2]), 64'(6'b000011));
        idle_inputs();

        // Reset in the middle of MD_WAIT, then a full-length mul/div.
        exe_md_start = 1;
        run_cycle();
        exe_md_start = 0;
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check_value("rst_outputs", 64'({obs_ctl, obs_state}), 64'd0);
        rst = 1'b0;
        done_at = -1;
        exe_md_start = 1;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            exe_md_start = 0;
            if (obs_ctl[8] && done_at < 0) done_at = i;
        end
        check_value("rst_md_full", 64'(done_at), 64'(MD_LAT - 1));

        // Twenty stalled cycles from a clean reset.
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        mem_req = 1;
        for (int i = 0; i < 20; i++) run_cycle();
        mem_req = 0;
        run_cycle();
`ifdef HAZARD_CTRL_PERF_EN
        check_value("perf_sat", 64'(perf_stall_cnt), 64'd15);
`else
        check_value("perf_tied", 64'(perf_stall_cnt), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            id_rs1_idx   = 5'($urandom_range(0, 3));
            id_rs2_idx   = 5'($urandom_range(0, 3));
            exe_rd_idx   = 5'($urandom_range(0, 3));
            id_rs1_en    = 1'($urandom_range(0, 1));
            id_rs2_en    = 1'($urandom_range(0, 1));
            exe_rd_en    = ($urandom_range(0, 3) != 0);
            exe_is_load  = ($urandom_range(0, 2) == 0);
            exe_md_start = ($urandom_range(0, 11) == 0);
            exe_br_taken = ($urandom_range(0, 6) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ack      = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
